// File: rtl/fb_clock_divider.sv
// Programmable integer feedback divider with glitch-free ratio switching and a
// settled-output qualifier for the downstream edge-time monitor.
module fb_clock_divider #(
  parameter int unsigned DIV_WIDTH      = 8,
  parameter int unsigned SETTLE_PERIODS = 2,
  parameter int unsigned COUNT_WIDTH    = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [DIV_WIDTH-1:0]   div_ratio,
  input  logic                   ratio_load,
  output logic                   div_clock,
  output logic                   div_valid,
  output logic [COUNT_WIDTH-1:0] period_count,
  output logic                   ratio_error
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  localparam logic [3:0]           SettleMax = 4'(SETTLE_PERIODS);
  localparam logic [DIV_WIDTH-1:0] MinRatio  = DIV_WIDTH'(2);

  state_e                 state_q;
  logic [DIV_WIDTH-1:0]   cnt_q;
  logic [DIV_WIDTH-1:0]   active_q;
  logic [DIV_WIDTH-1:0]   shadow_q;
  logic                   pending_q;
  logic [3:0]             settle_q;
  logic                   div_clock_q;
  logic                   div_valid_q;
  logic [COUNT_WIDTH-1:0] period_count_q;
  logic                   ratio_error_q;

  logic                 at_boundary;
  logic [DIV_WIDTH-1:0] high_len;
  logic [DIV_WIDTH-1:0] cnt_nxt;
  logic                 clk_nxt;
  logic [DIV_WIDTH-1:0] load_ratio;
  logic                 load_bad;
  logic [3:0]           settle_inc;

  always_comb begin
    at_boundary = (cnt_q == active_q - DIV_WIDTH'(1));
    // High phase is ceil(R/2) so the odd cycle lands in the high half.
    high_len    = active_q - (active_q >> 1);
    cnt_nxt     = at_boundary ? '0 : cnt_q + DIV_WIDTH'(1);
    clk_nxt     = (cnt_nxt < high_len);
    load_bad    = (div_ratio < MinRatio);
    load_ratio  = load_bad ? MinRatio : div_ratio;
    settle_inc  = (settle_q >= SettleMax) ? SettleMax : settle_q + 4'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      active_q       <= MinRatio;
      shadow_q       <= MinRatio;
      pending_q      <= 1'b0;
      settle_q       <= '0;
      div_clock_q    <= 1'b0;
      div_valid_q    <= 1'b0;
      period_count_q <= '0;
      ratio_error_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          div_clock_q <= 1'b0;
          if (start && !stop) begin
            state_q        <= StRun;
            cnt_q          <= '0;
            div_clock_q    <= 1'b1;
            active_q       <= shadow_q;
            pending_q      <= 1'b0;
            settle_q       <= '0;
            period_count_q <= '0;
          end
        end
        StRun: begin
          cnt_q       <= cnt_nxt;
          div_clock_q <= clk_nxt;
          if (at_boundary) begin
            if (div_valid_q) begin
              period_count_q <= period_count_q + COUNT_WIDTH'(1);
            end
            if (pending_q) begin
              active_q    <= shadow_q;
              pending_q   <= 1'b0;
              settle_q    <= '0;
              div_valid_q <= 1'b0;
            end else begin
              settle_q <= settle_inc;
              if (settle_inc == SettleMax) begin
                div_valid_q <= 1'b1;
              end
            end
          end
          if (stop) begin
            div_valid_q <= 1'b0;
            state_q     <= StDrain;
          end
        end
        StDrain: begin
          if (at_boundary) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            div_clock_q <= 1'b0;
          end else begin
            cnt_q       <= cnt_nxt;
            div_clock_q <= clk_nxt;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Placed after the FSM so a load on a boundary or start edge stays pending.
      if (ratio_load) begin
        shadow_q  <= load_ratio;
        pending_q <= 1'b1;
        if (load_bad) begin
          ratio_error_q <= 1'b1;
        end
      end
    end
  end

  assign div_clock    = div_clock_q;
  assign div_valid    = div_valid_q;
  assign period_count = period_count_q;
  assign ratio_error  = ratio_error_q;

endmodule
